uio_bank_arbiter: RTL and testbench

//  Time-shares the 8-bit bidirectional uio pin bank between NREQ on-chip requesters.

---
 rtl/uio_arb_pkg.sv | 19 +
 rtl/uio_bank_arbiter_if.sv | 30 +++
 rtl/rr_pick.sv | 29 ++
 rtl/uio_bank_arbiter.sv | 179 +++++++++++++++++
 tb/tb_uio_bank_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uio_arb_pkg.sv
// Shared types and widths for the uio pin-bank arbiter.
// Holds the arbiter state encoding and the fixed pin and owner field widths.
package uio_arb_pkg;

    localparam int UIO_W   = 8;
    localparam int OWNER_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        OWN  = 2'd2
    } arb_state_t;

    // Counter/index width for a range of n values, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uio_bank_arbiter_if.sv
// Requester-side and pin-side signals of the uio bank arbiter.
// The arbiter uses the slave modport; the user logic side uses master.
interface uio_bank_arbiter_if
    import uio_arb_pkg::*;
#(
    parameter int NREQ = 4
);

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       gnt;
    logic [UIO_W*NREQ-1:0] req_out;
    logic [UIO_W*NREQ-1:0] req_oe;
    logic [UIO_W-1:0]      uio_in;
    logic [UIO_W-1:0]      uio_out;
    logic [UIO_W-1:0]      uio_oe;
    logic [UIO_W-1:0]      in_sync;
    logic                  busy;
    logic [OWNER_W-1:0]    owner;

    modport master (
        output req, req_out, req_oe, uio_in,
        input  gnt, uio_out, uio_oe, in_sync, busy, owner
    );

    modport slave (
        input  req, req_out, req_oe, uio_in,
        output gnt, uio_out, uio_oe, in_sync, busy, owner
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// any is high when at least one request is set; idx is 0 otherwise.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int j;
        // NOTE: every output gets a default before any branch, so no path can infer a latch.
        idx = '0;
        any = 1'b0;
        j   = 0;
        // Walk from the farthest slot back to ptr so the last hit is the highest priority.
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % NREQ;
            if (req[j]) begin
                idx = IDX_W'(j);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uio_bank_arbiter.sv
// Time-shares the 8-bit uio pin bank between NREQ requesters with round-robin
// arbitration and an all-inputs turnaround window between successive owners.
module uio_bank_arbiter
    import uio_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int TURN_CYC = 2,
    parameter int MAX_HOLD = 64
) (
    input  logic              clk,
    input  logic              rst,
    uio_bank_arbiter_if.slave bus
);

    localparam int IDX_W  = idx_width(NREQ);
    localparam int TURN_W = idx_width(TURN_CYC);
    localparam int HOLD_W = idx_width(MAX_HOLD);

    localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN_CYC - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NREQ - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [TURN_W-1:0] turn_q, turn_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [UIO_W-1:0]  pin_out_q, pin_out_d;
    logic [UIO_W-1:0]  pin_oe_q, pin_oe_d;
    logic [UIO_W-1:0]  sync_q1, sync_q2;

    logic [NREQ-1:0]   owner_mask;
    logic [NREQ-1:0]   pick_req;
    logic [IDX_W-1:0]  pick_ptr;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [IDX_W-1:0]  owner_inc;
    logic              owner_req;
    logic              preempt;
    logic              release_bank;

    assign owner_inc = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
    assign owner_req = bus.req[owner_q];

    // While owning, the owner is excluded and ranks last; elsewhere the stored pointer leads.
    always_comb begin
        owner_mask          = '0;
        owner_mask[owner_q] = 1'b1;
        if (state_q == OWN) begin
            pick_req = bus.req & ~owner_mask;
            pick_ptr = owner_inc;
        end else begin
            pick_req = bus.req;
            pick_ptr = ptr_q;
        end
    end

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (pick_req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // In OWN, pick_any means some other requester is waiting.
    assign preempt      = (MAX_HOLD != 0) && (int'(hold_q) >= MAX_HOLD - 1) && pick_any;
    assign release_bank = !owner_req || preempt;

    // State register, counters and registered pin outputs.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so rst only takes effect at a clock edge like any other input.
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            turn_q    <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            pin_out_q <= '0;
            pin_oe_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples pre-edge values regardless of order.
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            turn_q    <= turn_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            pin_out_q <= pin_out_d;
            pin_oe_q  <= pin_oe_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        turn_d  = turn_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = TURN;
                    owner_d = pick_idx;
                    turn_d  = TURN_LOAD;
                end
            end
            TURN: begin
                if (turn_q != '0) begin
                    turn_d = turn_q - TURN_W'(1);
                end else if (owner_req) begin
                    state_d = OWN;
                    hold_d  = '0;
                end else if (pick_any) begin
                    // Winner gave up during turnaround: start a fresh window for the next one.
                    owner_d = pick_idx;
                    turn_d  = TURN_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                if (release_bank) begin
                    ptr_d = owner_inc;
                    if (pick_any) begin
                        state_d = TURN;
                        owner_d = pick_idx;
                        turn_d  = TURN_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs follow the next state, so gnt and the pins change on the same edge.
    always_comb begin
        gnt_d     = '0;
        pin_out_d = '0;
        pin_oe_d  = '0;
        if (state_d == OWN) begin
            gnt_d[owner_d] = 1'b1;
            pin_out_d      = bus.req_out[int'(owner_d)*UIO_W +: UIO_W];
            pin_oe_d       = bus.req_oe[int'(owner_d)*UIO_W +: UIO_W];
        end
    end

    // Two-flop synchroniser for the pin input path, independent of arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= bus.uio_in;
            sync_q2 <= sync_q1;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.uio_out = pin_out_q;
    assign bus.uio_oe  = pin_oe_q;
    assign bus.in_sync = sync_q2;
    assign bus.busy    = (state_q != IDLE);
    assign bus.owner   = OWNER_W'(owner_q);

endmodule

// File: tb/tb_uio_bank_arbiter.sv
// Self-checking bench for uio_bank_arbiter: reset table, directed corner sequences,
// then randomized traffic against a cycle-level ownership model.
module tb_uio_bank_arbiter;

    localparam int NREQ     = 4;
    localparam int TURN_CYC = 2;
    localparam int MAX_HOLD = 8;

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [7:0] oe;
        logic       busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   fair_exp[5] = '{0, 1, 2, 3, 0};

    uio_bank_arbiter_if #(.NREQ(NREQ)) ifc ();

    uio_bank_arbiter #(
        .NREQ     (NREQ),
        .TURN_CYC (TURN_CYC),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    // Model: m_owner is the bank holder (-1 none), m_next the current or pending owner
    // (-1 when idle), m_left the turnaround cycles still to run, m_held OWN cycles so far.
    int         m_owner = -1;
    int         m_next  = -1;
    int         m_left  = 0;
    int         m_ptr   = 0;
    int         m_held  = 0;
    logic [7:0] e_out   = '0;
    logic [7:0] e_oe    = '0;
    logic [7:0] m_s1    = '0;
    logic [7:0] m_s2    = '0;

    function automatic int rr_first(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_gnt();
        logic [NREQ-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] g);
        if ($countones(g) != 1) return -1;
        for (int k = 0; k < NREQ; k++) if (g[k]) return k;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] others;
        r = ifc.req;
        if (rst) begin
            m_owner = -1; m_next = -1; m_left = 0; m_ptr = 0; m_held = 0;
            m_s1 = '0; m_s2 = '0;
        end else begin
            m_s2 = m_s1;
            m_s1 = ifc.uio_in;
            if (m_owner >= 0) begin
                m_held++;
                others = r;
                others[m_owner] = 1'b0;
                if (!r[m_owner] || (MAX_HOLD != 0 && m_held >= MAX_HOLD && others != '0)) begin
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_next  = rr_first(others, m_ptr);
                    m_left  = TURN_CYC;
                    m_owner = -1;
                end
            end else if (m_next >= 0) begin
                m_left--;
                if (m_left == 0) begin
                    if (r[m_next]) begin
                        m_owner = m_next;
                        m_held  = 0;
                    end else begin
                        m_next = rr_first(r, m_ptr);
                        m_left = TURN_CYC;
                    end
                end
            end else begin
                m_next = rr_first(r, m_ptr);
                m_left = TURN_CYC;
            end
        end
        if (m_owner >= 0) begin
            e_out = ifc.req_out[8*m_owner +: 8];
            e_oe  = ifc.req_oe[8*m_owner +: 8];
        end else begin
            e_out = '0;
            e_oe  = '0;
        end
    endtask

    // One clock: the model sees the same pre-edge inputs as the DUT, outputs are compared 1 unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("gnt", 32'(ifc.gnt), 32'(exp_gnt()));
        check("uio_out", 32'(ifc.uio_out), 32'(e_out));
        check("uio_oe", 32'(ifc.uio_oe), 32'(e_oe));
        check("busy", 32'(ifc.busy), 32'(m_next >= 0));
        if (m_next >= 0) check("owner", 32'(ifc.owner), m_next);
        check("in_sync", 32'(ifc.in_sync), 32'(m_s2));
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        ifc.req = '0;
        tick();
        rst     = 1'b0;
    endtask

    task automatic wait_gnt(input logic [NREQ-1:0] m, input string name);
        int w;
        w = 0;
        while (ifc.gnt != m && w < 50) begin
            tick();
            w++;
        end
        check(name, 32'(ifc.gnt), 32'(m));
    endtask

    initial begin
        vec_t            tbl[9];
        int              w, zeros, idx, held, gap, bad;
        logic            saw0;
        logic [NREQ-1:0] r;

        ifc.req     = '0;
        ifc.req_out = 32'h4433_2211;
        ifc.req_oe  = 32'hFFFF_FF0F;
        ifc.uio_in  = '0;

        // Reset with all requests high, release, first grant, then reset mid-OWN.
        tbl[0] = '{1'b1, 4'b1111, 4'b0000, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 4'b1111, 4'b0000, 8'h00, 1'b0};
        tbl[2] = '{1'b1, 4'b1111, 4'b0000, 8'h00, 1'b0};
        tbl[3] = '{1'b0, 4'b1111, 4'b0000, 8'h00, 1'b1};
        tbl[4] = '{1'b0, 4'b1111, 4'b0000, 8'h00, 1'b1};
        tbl[5] = '{1'b0, 4'b1111, 4'b0001, 8'h0F, 1'b1};
        tbl[6] = '{1'b0, 4'b1111, 4'b0001, 8'h0F, 1'b1};
        tbl[7] = '{1'b1, 4'b1111, 4'b0000, 8'h00, 1'b0};
        tbl[8] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0};
        for (int i = 0; i < 9; i++) begin
            rst     = tbl[i].rst;
            ifc.req = tbl[i].req;
            tick();
            check("tbl_gnt", 32'(ifc.gnt), 32'(tbl[i].gnt));
            check("tbl_oe", 32'(ifc.uio_oe), 32'(tbl[i].oe));
            check("tbl_busy", 32'(ifc.busy), 32'(tbl[i].busy));
            if (tbl[i].rst) begin
                check("tbl_rst_owner", 32'(ifc.owner), 32'd0);
                check("tbl_rst_out", 32'(ifc.uio_out), 32'd0);
                check("tbl_rst_sync", 32'(ifc.in_sync), 32'd0);
            end
        end

        // Latency: owner 2 pin values appear exactly one edge after they are driven.
        do_reset();
        ifc.req_out = 32'h005A_0000;
        ifc.req_oe  = 32'h000F_0000;
        ifc.req     = 4'b0100;
        wait_gnt(4'b0100, "lat_grant");
        check("lat_first_out", 32'(ifc.uio_out), 32'h5A);
        check("lat_first_oe", 32'(ifc.uio_oe), 32'h0F);
        ifc.req_out[23:16] = 8'hA5;
        ifc.req_oe[23:16]  = 8'hFF;
        #1;
        check("lat_not_yet", 32'(ifc.uio_out), 32'h5A);
        tick();
        check("lat_out", 32'(ifc.uio_out), 32'hA5);
        check("lat_oe", 32'(ifc.uio_oe), 32'hFF);

        // Fairness: all four request, each owner lets go after 5 granted cycles.
        do_reset();
        ifc.req_oe  = '1;
        ifc.req_out = 32'hD4C3_B2A1;
        ifc.req     = 4'b1111;
        zeros       = 0;
        for (int g = 0; g < 5; g++) begin
            w = 0;
            while (ifc.gnt == '0 && w < 50) begin
                tick();
                w++;
                if (ifc.uio_oe == 8'h00) zeros++;
            end
            idx = onehot_idx(ifc.gnt);
            check("fair_order", idx, fair_exp[g]);
            if (g > 0) check("fair_gap", zeros, TURN_CYC);
            for (int c = 1; c < 5; c++) tick();
            if (idx >= 0) ifc.req[idx] = 1'b0;
            tick();
            zeros = (ifc.uio_oe == 8'h00) ? 1 : 0;
            if (idx >= 0) ifc.req[idx] = 1'b1;
        end

        // Preemption: requester 0 holds, requester 3 waits.
        do_reset();
        ifc.req = 4'b1001;
        wait_gnt(4'b0001, "pre_first");
        held = 0;
        while (ifc.gnt == 4'b0001 && held < 100) begin
            held++;
            tick();
        end
        check("pre_hold", held, MAX_HOLD);
        gap = 0;
        while (ifc.gnt == '0 && gap < 50) begin
            gap++;
            tick();
        end
        check("pre_gap", gap, TURN_CYC);
        check("pre_next", 32'(ifc.gnt), 32'b1000);

        // Lone owner keeps the bank well past MAX_HOLD.
        do_reset();
        ifc.req = 4'b0010;
        wait_gnt(4'b0010, "lone_first");
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (ifc.gnt != 4'b0010) bad++;
        end
        check("lone_hold", bad, 0);

        // Abort during turnaround, plus the input synchroniser delay.
        do_reset();
        ifc.uio_in = 8'h00;
        ifc.req    = 4'b0101;
        tick();
        check("abort_busy", 32'(ifc.busy), 32'd1);
        check("abort_owner0", 32'(ifc.owner), 32'd0);
        ifc.req    = 4'b0100;
        ifc.uio_in = 8'h3C;
        tick();
        check("sync_d1", 32'(ifc.in_sync), 32'h00);
        tick();
        check("sync_d2", 32'(ifc.in_sync), 32'h3C);
        check("abort_owner2", 32'(ifc.owner), 32'd2);
        saw0 = 1'b0;
        w    = 0;
        while (ifc.gnt == '0 && w < 50) begin
            tick();
            w++;
            if (ifc.gnt[0]) saw0 = 1'b1;
        end
        check("abort_no_gnt0", 32'(saw0), 32'd0);
        check("abort_gnt2", 32'(ifc.gnt), 32'b0100);
        check("abort_wait", w, TURN_CYC);

        // Random traffic with occasional resets, checked every cycle by the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            r = ifc.req;
            if ($urandom_range(0, 5) == 0) begin
                idx    = $urandom_range(0, NREQ - 1);
                r[idx] = ~r[idx];
            end
            ifc.req     = r;
            ifc.req_out = $urandom;
            ifc.req_oe  = $urandom;
            ifc.uio_in  = 8'($urandom);
            rst         = ($urandom_range(0, 249) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not reach its summary in time");
        $fatal(1, "watchdog expired");
    end

endmodule
